// File: rtl/array_cmd_ctrl.sv
// array_cmd_ctrl: UART command decoder that drives double-buffered transducer phase offsets.
// Optional op 011 READ is compiled in when ARRAY_CMD_READBACK_EN is defined.
`default_nettype none

module array_cmd_ctrl #(
    parameter int OUTPUTS      = 16,
    parameter int OFFSET_WIDTH = 11,
    parameter int TIMEOUT      = 50000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [OUTPUTS*OFFSET_WIDTH-1:0]  offsets,
    output logic                             reload,
    output logic                             frame_err
);

    localparam int          IDXW         = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int          TMOW         = $clog2(TIMEOUT);
    localparam logic [11:0] C_OUTPUTS12  = 12'(OUTPUTS);
    localparam logic [13:0] C_OUTPUTS14  = 14'(OUTPUTS);
    localparam logic [7:0]  C_ERR_OP     = 8'hE0;
    localparam logic [7:0]  C_ERR_CH     = 8'hE1;

    localparam logic [2:0]  OP_SET       = 3'b000;
    localparam logic [2:0]  OP_COMMIT    = 3'b001;
    localparam logic [2:0]  OP_QUERY     = 3'b010;
    localparam logic [2:0]  OP_READ      = 3'b011;
    localparam logic [2:0]  OP_SET_ALL   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EXEC    = 2'd2,
        S_REPLY   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [1:0]              cnt_q;
    logic [2:0]              op_q;
    logic [10:0]             ch_q;
    logic [13:0]             val_q;
    logic [TMOW-1:0]         tmo_q;
    logic [7:0]              reply2_q;
    logic                    reply_more_q;
    logic                    rx_ready_q;
    logic                    tx_valid_q;
    logic [7:0]              tx_data_q;
    logic                    reload_q;
    logic                    frame_err_q;
    logic [OFFSET_WIDTH-1:0] shadow_q [OUTPUTS];
    logic [OFFSET_WIDTH-1:0] active_q [OUTPUTS];

    logic                    rx_fire;
    logic                    tx_fire;
    logic                    ch_ok;
    logic [IDXW-1:0]         idx;
    logic [OFFSET_WIDTH-1:0] val_trunc;
    logic                    has_reply_d;
    logic                    reply_more_d;
    logic [7:0]              reply0_d;
    logic [7:0]              reply1_d;

    assign rx_fire   = rx_valid & rx_ready_q;
    assign tx_fire   = tx_valid_q & tx_ready;
    assign ch_ok     = {1'b0, ch_q} < C_OUTPUTS12;
    assign idx       = IDXW'(ch_q);
    assign val_trunc = OFFSET_WIDTH'(val_q);

    // Reply selection for the command held in EXEC
    always_comb begin
        has_reply_d  = 1'b0;
        reply_more_d = 1'b0;
        reply0_d     = 8'h00;
        reply1_d     = 8'h00;
        case (op_q)
            OP_SET: begin
                if (!ch_ok) begin
                    has_reply_d = 1'b1;
                    reply0_d    = C_ERR_CH;
                end
            end
            OP_COMMIT, OP_SET_ALL: begin
                has_reply_d = 1'b0;
            end
            OP_QUERY: begin
                has_reply_d  = 1'b1;
                reply_more_d = 1'b1;
                reply0_d     = {1'b0, C_OUTPUTS14[13:7]};
                reply1_d     = {1'b0, C_OUTPUTS14[6:0]};
            end
`ifdef ARRAY_CMD_READBACK_EN
            OP_READ: begin
                has_reply_d = 1'b1;
                if (!ch_ok) begin
                    reply0_d = C_ERR_CH;
                end else begin
                    reply_more_d = 1'b1;
                    reply0_d     = {1'b0, 7'((14'(shadow_q[idx])) >> 7)};
                    reply1_d     = {1'b0, 7'(shadow_q[idx])};
                end
            end
`endif
            default: begin
                has_reply_d = 1'b1;
                reply0_d    = C_ERR_OP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            op_q         <= 3'd0;
            ch_q         <= 11'd0;
            val_q        <= 14'd0;
            tmo_q        <= '0;
            reply2_q     <= 8'h00;
            reply_more_q <= 1'b0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            reload_q     <= 1'b1;
            frame_err_q  <= 1'b0;
            for (int i = 0; i < OUTPUTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            frame_err_q <= 1'b0;
            reload_q    <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire) begin
                        if (rx_data[7]) begin
                            op_q       <= rx_data[6:4];
                            ch_q[10:7] <= rx_data[3:0];
                            cnt_q      <= 2'd1;
                            tmo_q      <= '0;
                            state_q    <= S_COLLECT;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (rx_fire) begin
                        tmo_q <= '0;
                        if (rx_data[7]) begin
                            // A header byte mid-frame restarts the frame with this byte as B0
                            frame_err_q <= 1'b1;
                            op_q        <= rx_data[6:4];
                            ch_q[10:7]  <= rx_data[3:0];
                            cnt_q       <= 2'd1;
                        end else begin
                            case (cnt_q)
                                2'd1:    ch_q[6:0]   <= rx_data[6:0];
                                2'd2:    val_q[13:7] <= rx_data[6:0];
                                default: val_q[6:0]  <= rx_data[6:0];
                            endcase
                            if (cnt_q == 2'd3) begin
                                state_q    <= S_EXEC;
                                rx_ready_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 2'd1;
                            end
                        end
                    end else if (tmo_q == TMOW'(TIMEOUT - 1)) begin
                        frame_err_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (has_reply_d) begin
                        state_q      <= S_REPLY;
                        tx_valid_q   <= 1'b1;
                        tx_data_q    <= reply0_d;
                        reply2_q     <= reply1_d;
                        reply_more_q <= reply_more_d;
                    end else begin
                        state_q    <= S_IDLE;
                        rx_ready_q <= 1'b1;
                    end
                    case (op_q)
                        OP_SET: begin
                            if (ch_ok) begin
                                shadow_q[idx] <= val_trunc;
                            end
                        end
                        OP_COMMIT: begin
                            reload_q <= 1'b0;
                            for (int i = 0; i < OUTPUTS; i++) begin
                                active_q[i] <= shadow_q[i];
                            end
                        end
                        OP_SET_ALL: begin
                            for (int i = 0; i < OUTPUTS; i++) begin
                                shadow_q[i] <= val_trunc;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                S_REPLY: begin
                    if (tx_fire) begin
                        if (reply_more_q) begin
                            tx_data_q    <= reply2_q;
                            reply_more_q <= 1'b0;
                        end else begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < OUTPUTS; g++) begin : g_offsets
            assign offsets[g*OFFSET_WIDTH +: OFFSET_WIDTH] = active_q[g];
        end
    endgenerate

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign reload    = reload_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_array_cmd_ctrl.sv
// tb_array_cmd_ctrl: directed self-checking bench for array_cmd_ctrl (OUTPUTS=16, OFFSET_WIDTH=11).
`default_nettype none

module tb_array_cmd_ctrl;

    localparam int OUTPUTS = 16;
    localparam int OW      = 11;
    localparam int TMO     = 20;
    localparam int OFFW    = OUTPUTS * OW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic [OFFW-1:0] offsets;
    logic            reload;
    logic            frame_err;

    int tests = 0;
    int fails = 0;
    int reload_lows = 0;
    int err_pulses = 0;

    array_cmd_ctrl #(
        .OUTPUTS      (OUTPUTS),
        .OFFSET_WIDTH (OW),
        .TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .offsets   (offsets),
        .reload    (reload),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && !reload) reload_lows++;
        if (!rst && frame_err) err_pulses++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", 0, 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] op, input logic [10:0] ch, input logic [13:0] val);
        send_byte({1'b1, op, ch[10:7]});
        send_byte({1'b0, ch[6:0]});
        send_byte({1'b0, val[13:7]});
        send_byte({1'b0, val[6:0]});
    endtask

    task automatic get_byte(input int hold, output logic [7:0] b);
        int n = 0;
        int bad = 0;
        logic [7:0] first;
        b = 8'h00;
        @(negedge clk);
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            chk("tx_valid_wait", 0, 1);
        end else begin
            first = tx_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (tx_data !== first || !tx_valid || rx_ready) bad++;
            end
            if (hold > 0) chk("tx_hold_stable", bad, 0);
            b = tx_data;
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    function automatic logic [OFFW-1:0] fill(input logic [OW-1:0] v);
        logic [OFFW-1:0] r;
        for (int i = 0; i < OUTPUTS; i++) r[i*OW +: OW] = v;
        return r;
    endfunction

    logic [7:0]      rb;
    logic [OFFW-1:0] exp_off;
    int              base_err;
    int              n;

    initial begin
        // reset state
        #12;
        chk("rst_offsets", offsets, 0);
        chk("rst_reload", reload, 1);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready_after_rst", rx_ready, 1);

        // SET ch3 then COMMIT
        send_frame(3'b000, 11'd3, 14'h155);
        repeat (3) @(negedge clk);
        chk("set_no_offset_change", offsets, 0);
        send_frame(3'b001, 11'd0, 14'd0);
        @(negedge clk);
        exp_off = '0;
        exp_off[3*OW +: OW] = 11'h155;
        chk("commit_offsets", offsets, exp_off);
        chk("commit_reload_low", reload, 0);
        @(negedge clk);
        chk("commit_reload_high", reload, 1);
        chk("reload_low_count", reload_lows, 1);

        // SET ch0 without commit, then SET_ALL + COMMIT
        send_frame(3'b000, 11'd0, 14'h7FF);
        repeat (3) @(negedge clk);
        chk("set_ch0_no_commit", offsets, exp_off);
        chk("reload_still_high", reload_lows, 1);
        send_frame(3'b100, 11'd0, 14'h010);
        send_frame(3'b001, 11'd0, 14'd0);
        repeat (2) @(negedge clk);
        chk("set_all_commit", offsets, fill(11'h010));

        // QUERY with back-pressure
        send_frame(3'b010, 11'd0, 14'd0);
        get_byte(5, rb);
        chk("query_b0", rb, 8'h00);
        get_byte(0, rb);
        chk("query_b1", rb, 8'h10);
        chk("tx_valid_drop", tx_valid, 0);

        // broken frame then a good one
        base_err = err_pulses;
        send_byte(8'h80);
        send_byte(8'h01);
        send_frame(3'b000, 11'd5, 14'h007);
        chk("restart_err_pulse", err_pulses - base_err, 1);
        send_frame(3'b001, 11'd0, 14'd0);
        repeat (2) @(negedge clk);
        exp_off = fill(11'h010);
        exp_off[5*OW +: OW] = 11'h007;
        chk("restart_frame_exec", offsets, exp_off);

        // out-of-range channel and bad opcode
        send_frame(3'b000, 11'd16, 14'h3FF);
        get_byte(0, rb);
        chk("set_ch16_reply", rb, 8'hE1);
        send_frame(3'b101, 11'd0, 14'd0);
        get_byte(0, rb);
        chk("bad_op_reply", rb, 8'hE0);

        // data byte while idle
        base_err = err_pulses;
        send_byte(8'h05);
        @(negedge clk);
        chk("idle_data_err", err_pulses - base_err, 1);

        // readback
        send_frame(3'b000, 11'd2, 14'h123);
        send_frame(3'b011, 11'd2, 14'd0);
        get_byte(0, rb);
`ifdef ARRAY_CMD_READBACK_EN
        chk("read_b0", rb, 8'h02);
        get_byte(0, rb);
        chk("read_b1", rb, 8'h23);
`else
        chk("read_disabled", rb, 8'hE0);
`endif

        // timeout on a partial frame
        base_err = err_pulses;
        send_byte(8'hA0);
        repeat (TMO - 3) @(negedge clk);
        chk("tmo_not_yet", err_pulses - base_err, 0);
        repeat (8) @(negedge clk);
        chk("tmo_err_pulse", err_pulses - base_err, 1);
        send_frame(3'b010, 11'd0, 14'd0);
        get_byte(0, rb);
        chk("after_tmo_query_b0", rb, 8'h00);
        get_byte(0, rb);
        chk("after_tmo_query_b1", rb, 8'h10);

        // reset in the middle of a reply
        send_frame(3'b010, 11'd0, 14'd0);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reply_before_rst", tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx_valid", tx_valid, 0);
        chk("rst_mid_offsets", offsets, 0);
        chk("rst_mid_rx_ready", rx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rx_ready_up", rx_ready, 1);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_reply", tx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/array_cmd_ctrl.md
ARRAY_CMD_CTRL -- requirements
Module: array_cmd_ctrl

Interface
REQ-001 SHALL have parameter OUTPUTS, default 16, number of transducer channels (1..2048).
REQ-002 SHALL have parameter OFFSET_WIDTH, default 11, bits per channel phase offset (1..14).
REQ-003 SHALL have parameter TIMEOUT, default 50000, idle clk cycles before a partial frame is discarded (>=2).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports rx_data in 8, rx_valid in 1, rx_ready out 1: byte stream from UART receiver; byte accepted when rx_valid and rx_ready are both high.
REQ-007 SHALL have ports tx_data out 8, tx_valid out 1, tx_ready in 1: reply stream to UART transmitter; byte taken when tx_valid and tx_ready are both high.
REQ-008 SHALL have port offsets  out  OUTPUTS*OFFSET_WIDTH  active offset bank, channel i at bits [i*OFFSET_WIDTH +: OFFSET_WIDTH].
REQ-009 SHALL have port reload  out  1  active-low one-cycle pulse requesting oscillators to reload offsets.
REQ-010 SHALL have port frame_err  out  1  one-cycle pulse on any framing or timeout error.

Function
REQ-011 SHALL use 4-byte frames: B0={1,op[2:0],ch[10:7]}, B1={0,ch[6:0]}, B2={0,val[13:7]}, B3={0,val[6:0]}.
REQ-012 SHALL run FSM IDLE -> COLLECT (bytes 1..3) -> EXEC -> REPLY -> IDLE; EXEC lasts exactly one cycle; REPLY skipped when no reply.
REQ-013 SHALL keep two banks: shadow (written by commands) and active (drives offsets); value truncated to OFFSET_WIDTH LSBs.
REQ-014 SHALL implement op 000 SET: shadow[ch] <= val at the edge ending EXEC; no reply.
REQ-015 SHALL implement op 001 COMMIT: active <= shadow and reload low for exactly the cycle after EXEC; ch/val ignored; no reply.
REQ-016 SHALL implement op 010 QUERY: reply two bytes {0,OUTPUTS[13:7]} then {0,OUTPUTS[6:0]}.
REQ-017 SHALL implement op 100 SET_ALL: every shadow entry <= val in one edge; no reply.
REQ-018 SHALL reply single byte 0xE1 and change no state for SET/READ with ch >= OUTPUTS.
REQ-019 SHALL reply single byte 0xE0 for ops 101, 110, 111 (and 011 when readback excluded).
REQ-020 SHALL hold rx_ready low during EXEC and REPLY, high otherwise.
REQ-021 SHALL hold tx_data stable while tx_valid high and not ready; tx_valid drops the cycle after final reply byte handshake.
REQ-022 SHALL on a byte with MSB=1 during COLLECT pulse frame_err, discard partial frame, treat byte as new B0.
REQ-023 SHALL on a byte with MSB=0 in IDLE pulse frame_err and discard it.
REQ-024 SHALL on TIMEOUT consecutive cycles in COLLECT without an accepted byte pulse frame_err and return to IDLE; byte accepted in the expiry cycle wins.
REQ-025 SHALL keep offsets unchanged except at a COMMIT edge; SET never alters offsets directly.

Reset
REQ-026 SHALL on rst high asynchronously force: FSM IDLE, both banks zero, offsets 0, reload 1, frame_err 0, rx_ready 0, tx_valid 0, tx_data 0x00, timeout counter 0.
REQ-027 SHALL raise rx_ready on the first clk edge after rst deasserts; reset mid-frame or mid-reply discards it with no reply emitted.

Configuration
REQ-028 SHALL compile op 011 READ only when macro ARRAY_CMD_READBACK_EN is defined.
REQ-029 With ARRAY_CMD_READBACK_EN: READ replies {0,shadow[ch] bits 13:7} then {0,bits 6:0}, zero-extended to 14 bits.
REQ-030 Without ARRAY_CMD_READBACK_EN: op 011 replies 0xE0, no readback mux synthesised.

Verification
REQ-031 SET ch3=0x155 then COMMIT -> offsets ch3=0x155 one cycle after COMMIT EXEC, reload low exactly one cycle, other channels 0.
REQ-032 SET ch0=0x7FF without COMMIT -> offsets unchanged 0, reload stays 1; later SET_ALL 0x010 + COMMIT -> all channels 0x010.
REQ-033 QUERY with OUTPUTS=16 and tx_ready held low 5 cycles -> tx_data 0x00 stable then 0x10; rx_ready low throughout.
REQ-034 Send B0,B1 then new B0 -> frame_err one pulse, subsequent valid 4-byte frame executes normally; SET ch=16 (OUTPUTS=16) -> reply 0xE1.
REQ-035 Send B0 then idle TIMEOUT cycles -> frame_err pulse, FSM IDLE; rst asserted mid-reply -> tx_valid 0 immediately, offsets 0.
REQ-036 Op 011 ch2 after SET ch2=0x123 -> 0x02,0x23 with ARRAY_CMD_READBACK_EN; 0xE0 without.
